mdu32: RTL and testbench

MDU32 -- requirements
Module: mdu32

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mdu_absneg.sv | 18 +
 rtl/mdu32.sv | 171 +++++++++++++++++
 tb/tb_mdu32.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: multiply/divide op codes, MDU FSM states, iteration count.
// Pure declarations, no latency.
// No handshake; the control and hazard units share these encodings.
package mips_pkg;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_RUN  = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_signed(input mdu_op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input mdu_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_absneg.sv
// 32-bit conditional negate: neg ? (~in_dat + cin) : in_dat. cin chains two halves into a 64-bit negate.
// Combinational, zero latency.
// No flow control.
module mdu_absneg (
    input  logic [31:0] in_dat,
    input  logic        neg,
    input  logic        cin,
    output logic [31:0] out_dat
);

    always_comb begin
        out_dat = in_dat;
        if (neg) begin
            out_dat = ~in_dat + {31'b0, cin};
        end
    end

endmodule

// File: rtl/mdu32.sv
// Iterative 32-bit multiply/divide unit owning the architectural HI/LO registers.
// Latency: start at E0, HI/LO written at E33, done pulses the cycle after.
// busy blocks new starts and MTHI/MTLO; flush or reset abandons the operation.
module mdu32
    import mips_pkg::*;
#(
    parameter int ITER = MDU_ITER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2(ITER);

    mdu_state_e        state_q, state_d;
    mdu_op_e           op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       opnd_q, opnd_d;
    logic [63:0]       acc_q, acc_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              done_q, done_d;

    logic [31:0]       an0_in, an1_in, an0_out, an1_out;
    logic              an0_neg, an1_neg, an1_cin;
    logic [32:0]       sum33, diff33;
    logic              in_sgn;

    // The two negators are shared: operand magnitudes in IDLE, result sign fix in FIX.
    always_comb begin
        in_sgn  = op_is_signed(mdu_op_e'(op));
        an0_in  = a;
        an1_in  = b;
        an0_neg = in_sgn & a[31];
        an1_neg = in_sgn & b[31];
        an1_cin = 1'b1;
        if (state_q == MDU_FIX) begin
            an0_in  = acc_q[31:0];
            an1_in  = acc_q[63:32];
            an0_neg = neg_lo_q;
            an1_neg = neg_hi_q;
            an1_cin = op_is_div(op_q) ? 1'b1 : (acc_q[31:0] == 32'b0);
        end
    end

    mdu_absneg u_absneg_lo (
        .in_dat  (an0_in),
        .neg     (an0_neg),
        .cin     (1'b1),
        .out_dat (an0_out)
    );

    mdu_absneg u_absneg_hi (
        .in_dat  (an1_in),
        .neg     (an1_neg),
        .cin     (an1_cin),
        .out_dat (an1_out)
    );

    always_comb begin
        sum33  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'b0);
        diff33 = acc_q[63:31] - {1'b0, opnd_q};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            MDU_IDLE: begin
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
                if (start && !flush) begin
                    state_d = MDU_RUN;
                    op_d    = mdu_op_e'(op);
                    cnt_d   = '0;
                    if (op_is_div(mdu_op_e'(op))) begin
                        opnd_d   = an1_out;
                        acc_d    = {32'b0, an0_out};
                        // Divide by zero keeps the quotient at all ones regardless of signs.
                        neg_lo_d = in_sgn & (a[31] ^ b[31]) & (b != 32'b0);
                        neg_hi_d = in_sgn & a[31];
                    end else begin
                        opnd_d   = an0_out;
                        acc_d    = {32'b0, an1_out};
                        neg_lo_d = in_sgn & (a[31] ^ b[31]);
                        neg_hi_d = in_sgn & (a[31] ^ b[31]);
                    end
                end
            end
            MDU_RUN: begin
                if (op_is_div(op_q)) begin
                    if (!diff33[32]) acc_d = {diff33[31:0], acc_q[30:0], 1'b1};
                    else             acc_d = {acc_q[62:0], 1'b0};
                end else begin
                    acc_d = {sum33, acc_q[31:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) state_d = MDU_FIX;
            end
            MDU_FIX: begin
                hi_d    = an1_out;
                lo_d    = an0_out;
                done_d  = 1'b1;
                state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase

        if (flush && state_q != MDU_IDLE) begin
            state_d = MDU_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MDU_IDLE;
            op_q     <= OP_MULT;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != MDU_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu32.sv
// Randomized self-checking bench for mdu32 against a plain-arithmetic HI/LO model.
module tb_mdu32;

    logic        clk = 1'b0;
    logic        reset, start, flush, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi, exp_lo;

    always #5 clk = ~clk;

    mdu32 #(.ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference result {HI, LO} from the architectural definition.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            2'b00: return 64'(sx * sy);
            2'b01: return ux * uy;
            2'b10: begin
                if (y == 32'b0) return {x, 32'hFFFFFFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'b0) return {x, 32'hFFFFFFFF};
                return {32'(ux % uy), 32'(ux / uy)};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 7)
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic mt(input bit h, input bit l, input logic [31:0] d);
        wr_hi = h; wr_lo = l; wdata = d;
        step();
        wr_hi = 0; wr_lo = 0;
        if (h) exp_hi = d;
        if (l) exp_lo = d;
        chk("mt_hi", hi, exp_hi);
        chk("mt_lo", lo, exp_lo);
    endtask

    task automatic no_done(input string tag);
        bit seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) seen = 1;
            step();
        end
        chk({tag, "_nodone"}, seen, 0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit wr_also, input string tag);
        logic [63:0] r;
        int n;
        bit bad;
        r = model(o, x, y);
        op = o; a = x; b = y; start = 1;
        if (wr_also) begin wr_hi = 1; wr_lo = 1; wdata = $urandom; end
        step();
        start = 0; wr_hi = 0; wr_lo = 0;
        if (wr_also) begin
            chk({tag, "_wr_hi"}, hi, wdata);
            chk({tag, "_wr_lo"}, lo, wdata);
        end
        a = $urandom; b = $urandom; op = 2'($urandom);
        chk({tag, "_busy"}, busy, 1);
        n = 0;
        bad = 0;
        while (!done && n < 40) begin
            if (!busy) bad = 1;
            start = 1'($urandom); wr_hi = 1'($urandom); wr_lo = 1'($urandom); wdata = $urandom;
            step();
            n++;
        end
        start = 0; wr_hi = 0; wr_lo = 0;
        chk({tag, "_lat"}, n, 33);
        chk({tag, "_busy_hold"}, bad, 0);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_hi"}, hi, r[63:32]);
        chk({tag, "_lo"}, lo, r[31:0]);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        step();
        chk({tag, "_done_1cyc"}, done, 0);
    endtask

    initial begin
        bit bad;
        reset = 1; start = 1; flush = 0; wr_hi = 1; wr_lo = 1; wdata = 32'hDEADBEEF;
        op = 2'b00; a = 32'h3; b = 32'h5;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 0; start = 0; wr_hi = 0; wr_lo = 0;
        exp_hi = 0; exp_lo = 0;
        step();
        chk("rst_idle", busy, 0);

        do_op(2'b00, 32'hFFFFFFFD, 32'h7, 0, "mult_neg3x7");
        chk("mult_neg3x7_hi_lit", hi, 32'hFFFFFFFF);
        chk("mult_neg3x7_lo_lit", lo, 32'hFFFFFFEB);
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "multu_max");
        chk("multu_max_hi_lit", hi, 32'hFFFFFFFE);
        chk("multu_max_lo_lit", lo, 32'h00000001);
        do_op(2'b10, 32'hFFFFFFF9, 32'h2, 0, "div_neg7by2");
        chk("div_neg7by2_lo_lit", lo, 32'hFFFFFFFD);
        chk("div_neg7by2_hi_lit", hi, 32'hFFFFFFFF);
        do_op(2'b11, 32'h12345678, 32'h0, 0, "divu_by0");
        chk("divu_by0_hi_lit", hi, 32'h12345678);
        chk("divu_by0_lo_lit", lo, 32'hFFFFFFFF);
        do_op(2'b10, 32'hFFFFFFF9, 32'h0, 0, "div_neg_by0");
        chk("div_neg_by0_hi_lit", hi, 32'hFFFFFFF9);
        chk("div_neg_by0_lo_lit", lo, 32'hFFFFFFFF);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, "div_ovf");
        chk("div_ovf_lo_lit", lo, 32'h80000000);
        chk("div_ovf_hi_lit", hi, 32'h0);
        do_op(2'b00, 32'h80000000, 32'h80000000, 1, "mult_minsq_wr");

        // Flush mid-operation after an ignored second start.
        mt(1, 0, 32'h5);
        mt(0, 1, 32'h9);
        op = 2'b01; a = $urandom | 32'h1; b = $urandom | 32'h1; start = 1;
        step();
        start = 0;
        bad = 0;
        for (int k = 1; k <= 10; k++) begin
            start = (k == 5);
            flush = (k == 10);
            step();
            if (k < 10 && !busy) bad = 1;
        end
        start = 0; flush = 0;
        chk("flush_busy_hold", bad, 0);
        chk("flush_busy_low", busy, 0);
        chk("flush_hi", hi, 32'h5);
        chk("flush_lo", lo, 32'h9);
        no_done("flush");

        // MTHI ignored while busy, then flush in the final FIX cycle.
        op = 2'b00; a = $urandom; b = $urandom; start = 1;
        step();
        start = 0;
        for (int k = 1; k <= 33; k++) begin
            wr_hi = (k == 3);
            wdata = 32'hA5A5A5A5;
            flush = (k == 33);
            step();
            if (k == 3) chk("busy_wr_hi", hi, exp_hi);
        end
        wr_hi = 0; flush = 0;
        chk("fix_flush_busy", busy, 0);
        chk("fix_flush_done", done, 0);
        no_done("fix_flush");
        mt(1, 0, 32'hA5A5A5A5);

        // Flush with start in IDLE: start dropped, MTLO still applies.
        op = 2'b01; a = 32'h7; b = 32'h7; start = 1; flush = 1; wr_lo = 1; wdata = 32'h13579BDF;
        step();
        start = 0; flush = 0; wr_lo = 0;
        exp_lo = 32'h13579BDF;
        chk("idle_flush_start_busy", busy, 0);
        chk("idle_flush_lo", lo, exp_lo);
        no_done("idle_flush");

        // Reset in the middle of a divide.
        op = 2'b10; a = $urandom; b = $urandom | 32'h1; start = 1;
        step();
        start = 0;
        for (int k = 1; k <= 20; k++) begin
            reset = (k == 20);
            step();
        end
        reset = 0;
        exp_hi = 0; exp_lo = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        no_done("midrst");

        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom), pick(), pick(), ($urandom % 4) == 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
